norm_div: RTL

Sequential normalizer downstream of the 3x3 magnitude stage. Takes the nine 10-bit window values and their 11-bit L2 magnitude, and divides each value by the magnitude using a radix-2 restoring divider. Results stream out one element at a time as unsigned fixed-point fractions (FRAC fraction bits), with a valid/ready handshake.

---
 rtl/norm_div.sv | 137 +++++++++++++
 1 files changed

// File: rtl/norm_div.sv
// Normalizes a 3x3 window by its L2 magnitude: one restoring radix-2 divide per
// element, streamed out as U1.FRAC fractions. Define NORM_DIV_ROUND_EN for round-to-nearest.
module norm_div #(
  parameter int FRAC = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [9:0]        da,
  input  logic [9:0]        db,
  input  logic [9:0]        dc,
  input  logic [9:0]        dd,
  input  logic [9:0]        de,
  input  logic [9:0]        df,
  input  logic [9:0]        dg,
  input  logic [9:0]        dh,
  input  logic [9:0]        di,
  input  logic [10:0]       magnitude,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FRAC:0]     q,
  output logic [3:0]        out_idx,
  output logic              out_last
);
  localparam int DW = 10 + FRAC;
  localparam int OW = FRAC + 1;
`ifdef NORM_DIV_ROUND_EN
  localparam int QW = DW + 1;
`else
  localparam int QW = DW;
`endif
  localparam int CW = $clog2(QW + 1);
  localparam logic [QW-1:0] ONE = QW'(1) << FRAC;

  typedef enum logic [1:0] {IDLE, LOAD, DIV, OUT} state_t;

  state_t        state;
  logic [9:0]    d_lat [9];
  logic [10:0]   mag;
  logic [3:0]    idx;
  logic [QW-1:0] dvd;
  logic [QW-1:0] quo;
  logic [11:0]   rem;
  logic [CW-1:0] cnt;

  logic [11:0]   rem_sh;
  logic          take;
  logic [11:0]   rem_nx;
  logic [QW-1:0] quo_nx;
  logic [QW-1:0] dvd_ld;
  logic [OW-1:0] q_sat;

  // One restoring step; the guard bit keeps the shifted remainder from overflowing.
  always_comb begin
    rem_sh = {rem[10:0], dvd[QW-1]};
    take   = (rem_sh >= {1'b0, mag});
    rem_nx = take ? (rem_sh - {1'b0, mag}) : rem_sh;
    quo_nx = {quo[QW-2:0], take};
`ifdef NORM_DIV_ROUND_EN
    dvd_ld = (QW'(d_lat[idx]) << FRAC) + QW'(mag >> 1);
`else
    dvd_ld = QW'(d_lat[idx]) << FRAC;
`endif
    q_sat  = (quo_nx > ONE) ? ONE[OW-1:0] : quo_nx[OW-1:0];
  end

  assign out_idx = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      q         <= '0;
      idx       <= '0;
      mag       <= '0;
      dvd       <= '0;
      quo       <= '0;
      rem       <= '0;
      cnt       <= '0;
      for (int i = 0; i < 9; i++) d_lat[i] <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          d_lat[0] <= da; d_lat[1] <= db; d_lat[2] <= dc;
          d_lat[3] <= dd; d_lat[4] <= de; d_lat[5] <= df;
          d_lat[6] <= dg; d_lat[7] <= dh; d_lat[8] <= di;
          mag      <= magnitude;
          idx      <= '0;
          in_ready <= 1'b0;
          state    <= LOAD;
        end
        LOAD: begin
          dvd <= dvd_ld;
          rem <= '0;
          quo <= '0;
          cnt <= CW'(QW);
          if (mag == '0) begin
            q         <= '0;
            out_valid <= 1'b1;
            out_last  <= (idx == 4'd8);
            state     <= OUT;
          end else begin
            state <= DIV;
          end
        end
        DIV: begin
          dvd <= dvd << 1;
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            q         <= q_sat;
            out_valid <= 1'b1;
            out_last  <= (idx == 4'd8);
            state     <= OUT;
          end
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          if (idx == 4'd8) begin
            idx      <= '0;
            in_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            idx   <= idx + 1'b1;
            state <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
